// File: rtl/rom_burst_reader_if.sv
// Signal bundle between a burst reader, the ROM it addresses and its downstream consumer.
// The slave modport is the reader; the master modport is everything around it.
interface rom_burst_reader_if;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic [7:0] address;
  logic       rom_en;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic [7:0] out_addr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] checksum;

  modport master (
    output start, start_addr, len, rom_data, out_ready,
    input  busy, done, address, rom_en, out_data, out_addr, out_valid, checksum
  );

  modport slave (
    input  start, start_addr, len, rom_data, out_ready,
    output busy, done, address, rom_en, out_data, out_addr, out_valid, checksum
  );
endinterface

// File: rtl/rom_burst_reader.sv
// Burst read engine: issues ROM addresses under FIFO credit, captures returned bytes after
// RD_LAT cycles, streams them downstream on valid/ready and keeps a running 8-bit checksum.
module rom_burst_reader #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  rom_burst_reader_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_rom_en;
  logic [7:0]    r_addr;
  logic [8:0]    r_remain;
  logic [CW-1:0] r_occ;
  logic [7:0]    r_checksum;

  logic [RD_LAT-1:0] r_pipe_v;
  logic [7:0]        r_pipe_a [RD_LAT];

  logic [7:0]    r_mem_data [FIFO_DEPTH];
  logic [7:0]    r_mem_addr [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic [7:0]    r_out_addr;

  logic          w_pop;
  logic          w_wr;
  logic          w_issue;
  logic [CW-1:0] w_occ_next;
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] w_wptr_next;
  logic [AW-1:0] w_rptr_next;
  logic [7:0]    w_head_data;
  logic [7:0]    w_head_addr;

  // r_occ counts bytes issued (including the one on the bus now) but not yet popped;
  // a pop in the current cycle frees credit only from the next decision onward.
  always_comb begin
    w_pop        = r_out_valid & bus.out_ready;
    w_wr         = r_pipe_v[RD_LAT-1];
    w_issue      = 1'b0;
    if (r_state == S_IDLE) begin
      w_issue = bus.start;
    end else if (r_state == S_ISSUE) begin
      w_issue = (r_remain != 9'd0) && (r_occ < DEPTH_C);
    end else begin
      w_issue = 1'b0;
    end
    w_occ_next   = r_occ + {{(CW-1){1'b0}}, w_issue} - {{(CW-1){1'b0}}, w_pop};
    w_count_next = r_count + {{(CW-1){1'b0}}, w_wr} - {{(CW-1){1'b0}}, w_pop};
    w_wptr_next  = w_wr  ? (r_wptr + PTR_ONE) : r_wptr;
    w_rptr_next  = w_pop ? (r_rptr + PTR_ONE) : r_rptr;
    // A write landing on the next head slot bypasses the array into the output register.
    if (w_wr && (r_wptr == w_rptr_next)) begin
      w_head_data = bus.rom_data;
      w_head_addr = r_pipe_a[RD_LAT-1];
    end else begin
      w_head_data = r_mem_data[w_rptr_next];
      w_head_addr = r_mem_addr[w_rptr_next];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rom_en   <= 1'b0;
      r_addr     <= 8'h00;
      r_remain   <= 9'd0;
      r_occ      <= {CW{1'b0}};
      r_checksum <= 8'h00;
    end else begin
      r_done   <= 1'b0;
      r_rom_en <= w_issue;
      r_occ    <= w_occ_next;
      if (w_pop) begin
        r_checksum <= r_checksum + r_out_data;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_ISSUE;
            r_busy     <= 1'b1;
            r_addr     <= bus.start_addr;
            r_remain   <= (bus.len == 8'd0) ? 9'd255 : ({1'b0, bus.len} - 9'd1);
            r_checksum <= 8'h00;
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_addr   <= r_addr + 8'd1;
            r_remain <= r_remain - 9'd1;
          end else if (r_remain == 9'd0) begin
            if (w_occ_next == {CW{1'b0}}) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_occ_next == {CW{1'b0}}) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pipe_v <= {RD_LAT{1'b0}};
      for (int k = 0; k < RD_LAT; k++) begin
        r_pipe_a[k] <= 8'h00;
      end
    end else begin
      r_pipe_v[0] <= r_rom_en;
      r_pipe_a[0] <= r_addr;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pipe_v[k] <= r_pipe_v[k-1];
        r_pipe_a[k] <= r_pipe_a[k-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem_data[r_wptr] <= bus.rom_data;
      r_mem_addr[r_wptr] <= r_pipe_a[RD_LAT-1];
    end
  end

  // Output registers always hold the FIFO head so out_valid tracks a non-empty FIFO.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr      <= {AW{1'b0}};
      r_rptr      <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_addr  <= 8'h00;
    end else begin
      r_wptr      <= w_wptr_next;
      r_rptr      <= w_rptr_next;
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != {CW{1'b0}});
      if (w_count_next != {CW{1'b0}}) begin
        r_out_data <= w_head_data;
        r_out_addr <= w_head_addr;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.address   = r_addr;
  assign bus.rom_en    = r_rom_en;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.checksum  = r_checksum;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader with a 1-cycle ROM returning addr ^ 0xA5.
module tb_rom_burst_reader;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  logic [7:0] hs_data_q [$];
  logic [7:0] hs_addr_q [$];
  logic [7:0] iss_q [$];
  int         done_cnt;
  int         first_iss;
  int         last_iss;

  always #5 clk = ~clk;

  rom_burst_reader_if bus();

  rom_burst_reader #(.RD_LAT(1), .FIFO_DEPTH(4)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always @(posedge clk) bus.rom_data <= bus.address ^ 8'hA5;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.out_valid && bus.out_ready) begin
        hs_data_q.push_back(bus.out_data);
        hs_addr_q.push_back(bus.out_addr);
      end
      if (bus.rom_en) begin
        if (iss_q.size() == 0) first_iss = cyc;
        last_iss = cyc;
        iss_q.push_back(bus.address);
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    hs_data_q.delete();
    hs_addr_q.delete();
    iss_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_burst(input logic [7:0] a, input logic [7:0] l);
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.len        = l;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  function automatic logic [7:0] model_sum(input logic [7:0] base, input int n);
    logic [7:0] s = 8'h00;
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      s = s + (a ^ 8'hA5);
    end
    return s;
  endfunction

  task automatic check_seq(input string tag, input logic [7:0] base, input int n);
    int bad = 0;
    logic [7:0] a;
    check_eq({tag, "_issues"}, 32'(iss_q.size()), 32'(n));
    check_eq({tag, "_beats"}, 32'(hs_addr_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      if (i >= iss_q.size() || iss_q[i] !== a) bad++;
      if (i >= hs_addr_q.size() || hs_addr_q[i] !== a || hs_data_q[i] !== (a ^ 8'hA5)) bad++;
    end
    check_eq({tag, "_order"}, 32'(bad), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_address"}, 32'(bus.address), 32'h00);
    check_eq({tag, "_rom_en"}, 32'(bus.rom_en), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_out_data"}, 32'(bus.out_data), 32'h00);
    check_eq({tag, "_out_addr"}, 32'(bus.out_addr), 32'h00);
    check_eq({tag, "_checksum"}, 32'(bus.checksum), 32'h00);
  endtask

  // start in cycle 0: issue in cycle 1, data cycles 3..6, done in cycle 7
  task automatic run_basic(input string tag);
    logic [7:0] a;
    clear_mon();
    bus.out_ready = 1'b1;
    start_burst(8'h10, 8'd4);
    @(negedge clk);
    check_eq({tag, "_c1_busy"}, 32'(bus.busy), 32'd1);
    check_eq({tag, "_c1_rom_en"}, 32'(bus.rom_en), 32'd1);
    check_eq({tag, "_c1_address"}, 32'(bus.address), 32'h10);
    @(negedge clk);
    check_eq({tag, "_c2_valid"}, 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 8'h10 + 8'(i);
      check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(bus.out_data), 32'(a ^ 8'hA5));
      check_eq({tag, "_addr"}, 32'(bus.out_addr), 32'(a));
    end
    @(negedge clk);
    check_eq({tag, "_c7_done"}, 32'(bus.done), 32'd1);
    check_eq({tag, "_c7_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_c7_checksum"}, 32'(bus.checksum), 32'hD6);
    @(negedge clk);
    check_eq({tag, "_c8_done"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_c8_checksum"}, 32'(bus.checksum), 32'hD6);
    check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_issue_cnt"}, 32'(iss_q.size()), 32'd4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.start_addr = 8'h00;
    bus.len        = 8'd0;
    bus.out_ready  = 1'b0;
    done_cnt       = 0;
    first_iss      = 0;
    last_iss       = 0;
    tick();
    tick();
    @(negedge clk);
    check_reset_values("rst");
    tick();
    reset = 1'b0;

    run_basic("basic");

    // address wrap across 0xFF
    clear_mon();
    bus.out_ready = 1'b1;
    start_burst(8'hFE, 8'd4);
    wait_done(30, "wrap_done");
    tick();
    check_seq("wrap", 8'hFE, 4);
    check_eq("wrap_checksum", 32'(bus.checksum), 32'(model_sum(8'hFE, 4)));

    // len=0 means 256 bytes, one per cycle
    clear_mon();
    bus.out_ready = 1'b1;
    start_burst(8'h37, 8'd0);
    wait_done(400, "full_done");
    tick();
    check_seq("full", 8'h37, 256);
    check_eq("full_back2back", 32'(last_iss - first_iss), 32'd255);
    check_eq("full_checksum", 32'(bus.checksum), 32'(model_sum(8'h37, 256)));
    check_eq("full_done_cnt", 32'(done_cnt), 32'd1);

    // backpressure: only FIFO_DEPTH issues while out_ready is low
    clear_mon();
    bus.out_ready = 1'b0;
    start_burst(8'h20, 8'd10);
    repeat (10) @(negedge clk);
    check_eq("bp_stalled_issues", 32'(iss_q.size()), 32'd4);
    check_eq("bp_rom_en_low", 32'(bus.rom_en), 32'd0);
    check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
    check_eq("bp_head_data", 32'(bus.out_data), 32'(8'h20 ^ 8'hA5));
    check_eq("bp_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.out_ready = 1'b1;
    wait_done(80, "bp_done");
    tick();
    check_seq("bp", 8'h20, 10);
    check_eq("bp_checksum", 32'(bus.checksum), 32'(model_sum(8'h20, 10)));

    // start while busy is ignored
    clear_mon();
    bus.out_ready = 1'b1;
    start_burst(8'h40, 8'd6);
    tick();
    bus.start      = 1'b1;
    bus.start_addr = 8'h80;
    bus.len        = 8'd3;
    tick();
    bus.start      = 1'b0;
    wait_done(40, "busy_done");
    repeat (4) tick();
    check_seq("busy", 8'h40, 6);
    check_eq("busy_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("busy_idle", 32'(bus.busy), 32'd0);

    // reset in the middle of a burst
    clear_mon();
    bus.out_ready = 1'b1;
    start_burst(8'h50, 8'd8);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    clear_mon();
    repeat (10) tick();
    check_eq("midrst_no_beats", 32'(hs_data_q.size()), 32'd0);
    check_eq("midrst_no_issue", 32'(iss_q.size()), 32'd0);
    check_eq("midrst_no_done", 32'(done_cnt), 32'd0);
    check_eq("midrst_valid", 32'(bus.out_valid), 32'd0);

    run_basic("again");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Address-sequencing read engine that sits directly upstream of the ROM. It turns one burst request (start address, length) into a stream of ROM addresses. It captures the returned ROM bytes after a fixed read latency into a small FIFO and presents them downstream on a valid/ready handshake. It also accumulates a running 8-bit checksum of the bytes delivered.

## Interface
Parameters:
- RD_LAT, 1: ROM read latency in cycles from address issue to data valid. Legal range 1..3.
- FIFO_DEPTH, 4: output FIFO entries. Power of two, ≥ RD_LAT+3.

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  burst request, sampled when busy=0
- start_addr  input  8  first ROM address of the burst
- len  input  8  burst length in bytes; 0 encodes 256
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse after the last byte is accepted downstream
- address  output  8  ROM address; same signal the ROM input interface carries
- rom_en  output  1  address is a valid read request this cycle
- rom_data  input  8  ROM read data, valid RD_LAT cycles after rom_en
- out_data  output  8  delivered byte
- out_addr  output  8  ROM address the delivered byte came from
- out_valid  output  1  out_data/out_addr valid
- out_ready  input  1  downstream accepts when out_valid & out_ready
- checksum  output  8  sum mod 256 of bytes accepted in the current or last burst

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: busy=0. start=1 latches start_addr and len, clears checksum, and moves to ISSUE. start while busy=1 is ignored and not queued.
- ISSUE: rom_en=1 when credit is available. Credit is available when in_flight + fifo_count < FIFO_DEPTH. A same-cycle pop is not credited.
- Each issue increments address mod 256: 0xFF wraps to 0x00. The remaining count decrements on each issue.
- The last issue moves the block to DRAIN.
- In-flight tracking: an RD_LAT-deep shift register of {valid, addr}. When the valid bit emerges, rom_data and its addr are written to the FIFO. The FIFO cannot overflow by construction.
- DRAIN: no issues. When in_flight=0, fifo_count=0 and the final handshake has completed, the block pulses done for 1 cycle and returns to IDLE.
- Every handshake adds out_data to checksum (8-bit wrap). checksum holds after done until the next accepted start.
- Data order equals issue order; no bytes are dropped or duplicated under any out_ready pattern.
- Simultaneous FIFO write and read in one cycle: fifo_count is unchanged and both take effect.

## Timing
- Reset values: busy=0, done=0, address=0x00, rom_en=0, out_valid=0, out_data=0x00, out_addr=0x00, checksum=0x00. Reset also empties the FIFO and in-flight pipe and returns the state machine to IDLE.
- Reset mid-burst: all in-flight ROM data is discarded, and no done pulse is produced.
- All outputs are registered.
- start high in cycle 0 gives busy=1, rom_en=1 and address=start_addr in cycle 1.
- ROM data for that address is written to the FIFO at the end of cycle 1+RD_LAT. out_valid is first high in cycle 2+RD_LAT.
- With out_ready held at 1: one byte per cycle, and a len=N burst issues on N consecutive cycles.
- With out_ready held at 0: at most FIFO_DEPTH issues occur, then rom_en stays 0 until a pop.
- done is asserted in the cycle after the final handshake. busy falls in the same cycle done is high. A new start is accepted from that cycle onward.

## Test plan
- ROM model data = addr ^ 0xA5, RD_LAT=1. start_addr=0x10, len=4, out_ready=1 -> out_data A5^10, A5^11, A5^12, A5^13 in cycles 3..6. done in cycle 7. checksum = (B5+B4+B7+B6) mod 256 = 0xD6.
- Wrap: start_addr=0xFE, len=4 -> address sequence FE, FF, 00, 01. out_addr matches that sequence.
- Full length: len=0 -> exactly 256 handshakes covering addresses 00..FF once each. checksum equals the model sum mod 256.
- Backpressure, FIFO_DEPTH=4: start_addr=0x20, len=10, out_ready=0 for 10 cycles -> exactly 4 rom_en pulses, then rom_en stays 0. Releasing out_ready delivers bytes for 0x20..0x29 in order with no loss.
- start pulsed while busy=1 with start_addr=0x80 -> ignored. The burst completes unchanged, with exactly one done pulse.
- reset asserted for 1 cycle midway through a len=8 burst -> all outputs at their reset values the next cycle. No stale byte appears afterwards. A fresh start then behaves as in the first scenario.
